// File: rtl/display_multiplex_bcd_pkg.sv
// Shared definitions for the multiplexed BCD display.
//   state_t       conversion FSM states
//   SEG_DIGIT     7-segment codes for digits 0..9, S[6:0] = {a,b,c,d,e,f,g}
//   SEG_BLANK     all segments off
//   SEG_DASH      segment g only
//   bcd_nibbles() number of BCD nibbles needed to hold a DATA_W-bit binary value
package display_multiplex_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
        7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    // ceil(data_w * 0.302 + 1), computed in integer thousandths.
    function automatic int bcd_nibbles(input int data_w);
        return (data_w * 302 + 1999) / 1000;
    endfunction

endpackage

// File: rtl/display_multiplex_bcd_if.sv
// Request/display bundle for display_multiplex_bcd.
//   load, value, blank_zeros : driven by the requester (master)
//   S, AN, busy, done, ovf   : driven by the display block (slave)
interface display_multiplex_bcd_if #(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 14
);
    logic                load;
    logic [DATA_W-1:0]   value;
    logic                blank_zeros;
    logic [6:0]          S;
    logic [N_DIGITS-1:0] AN;
    logic                busy;
    logic                done;
    logic                ovf;

    modport master (
        output load, value, blank_zeros,
        input  S, AN, busy, done, ovf
    );

    modport slave (
        input  load, value, blank_zeros,
        output S, AN, busy, done, ovf
    );
endinterface

// File: rtl/display_multiplex_bcd_bcd_7seg.sv
// Combinational BCD digit to 7-segment encoder.
//   digit : BCD digit 0..9 (codes above 9 render blank)
//   blank : force all segments off
//   seg   : {a,b,c,d,e,f,g}, active-high
module bcd_7seg
    import display_multiplex_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/display_multiplex_bcd.sv
// Binary-to-BCD converter (double dabble, one bit per cycle) feeding a
// time-multiplexed 7-segment display.
//   clk, rst_n       : clock, synchronous active-low reset
//   bus.load/value   : one-cycle request to convert and show value
//   bus.blank_zeros  : live leading-zero blanking mode
//   bus.S / bus.AN   : registered segment pattern and one-hot digit enable
//   bus.busy / done  : conversion in progress / one-cycle commit pulse
//   bus.ovf          : displayed value does not fit in N_DIGITS digits
module display_multiplex_bcd
    import display_multiplex_bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    display_multiplex_bcd_if.slave bus
);

    localparam int NIB     = bcd_nibbles(DATA_W);
    // Scratch is widened to at least N_DIGITS nibbles so the commit slice is
    // always in range; the extra top nibbles simply stay zero.
    localparam int SCR_NIB = (NIB > N_DIGITS) ? NIB : N_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int PRE_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_t                     state, state_nxt;
    logic [DATA_W-1:0]          bin;
    logic [SCR_NIB-1:0][3:0]    scr, scr_adj;
    logic [4*SCR_NIB-1:0]       adj_flat;
    logic [CNT_W-1:0]           bit_cnt;
    logic [N_DIGITS-1:0][3:0]   digits;
    logic                       ovf_r, ovf_nxt, done_r;
    logic [PRE_W-1:0]           pre;
    logic [IDX_W-1:0]           idx;
    logic [N_DIGITS-1:0]        lead_zero, an_nxt, an_r;
    logic [3:0]                 cur_digit;
    logic                       cur_blank;
    logic [6:0]                 seg, s_r;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        for (int i = 0; i < SCR_NIB; i++) begin
            scr_adj[i] = (scr[i] >= 4'd5) ? scr[i] + 4'd3 : scr[i];
        end
        adj_flat = scr_adj;
    end

    // Any nonzero nibble beyond the visible digits means overflow.
    always_comb begin
        ovf_nxt = 1'b0;
        for (int i = N_DIGITS; i < SCR_NIB; i++) begin
            ovf_nxt = ovf_nxt | (scr[i] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin     <= '0;
            scr     <= '0;
            bit_cnt <= '0;
            digits  <= '0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin     <= bus.value;
                        scr     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    scr     <= {adj_flat[4*SCR_NIB-2:0], bin[DATA_W-1]};
                    bin     <= {bin[DATA_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    digits <= scr[N_DIGITS-1:0];
                    ovf_r  <= ovf_nxt;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan / display ----------------
    // lead_zero[i]: digit i and every more-significant digit are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[N_DIGITS-1] = (digits[N_DIGITS-1] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (digits[i] == 4'd0);
        end
    end

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            an_nxt[i] = (idx == IDX_W'(i));
        end
    end

    assign cur_digit = digits[idx];
    assign cur_blank = bus.blank_zeros && (idx != '0) && lead_zero[idx];

    bcd_7seg u_enc (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            idx  <= '0;
            s_r  <= '0;
            an_r <= '0;
        end else begin
            if (pre == PRE_W'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            s_r  <= ovf_r ? SEG_DASH : seg;
            an_r <= an_nxt;
        end
    end

    assign bus.S    = s_r;
    assign bus.AN   = an_r;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_display_multiplex_bcd.sv
// Self-checking bench: a cycle model based on decimal arithmetic and a
// conversion latency counter is compared against the DUT every cycle, and
// directed scenarios pin literal expectations.
module tb_display_multiplex_bcd;

    localparam int ND = 4;
    localparam int DW = 14;
    localparam int SD = 4;

    localparam logic [6:0] SEG_TBL [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [6:0] slot_s [ND];

    display_multiplex_bcd_if #(.N_DIGITS(ND), .DATA_W(DW)) bus ();

    display_multiplex_bcd #(.N_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected segment pattern for decimal position pos of value v.
    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit bz);
        int p;
        p = 10 ** pos;
        if (v > 9999) return 7'h01;
        if (bz && pos > 0 && v < p) return 7'h00;
        return SEG_TBL[(v / p) % 10];
    endfunction

    // ---------------- cycle model + compare ----------------
    initial begin
        int m_c, m_k, m_disp, m_pend, pos;
        logic [6:0] e_s;
        logic [3:0] e_an;
        bit e_busy, e_done, e_ovf;
        m_c = 0; m_k = 0; m_disp = 0; m_pend = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e_s = '0; e_an = '0; e_busy = 0; e_done = 0; e_ovf = 0;
                m_c = 0; m_k = 0; m_disp = 0;
            end else begin
                m_c++;
                pos    = ((m_c - 1) / SD) % ND;
                e_an   = 4'(1 << pos);
                e_s    = exp_seg(m_disp, pos, bus.blank_zeros);
                e_done = 0;
                if (m_k == DW + 1) begin
                    m_disp = m_pend; m_k = 0; e_done = 1;
                end else if (m_k > 0) begin
                    m_k++;
                end else if (bus.load) begin
                    m_pend = int'(bus.value); m_k = 1;
                end
                e_busy = (m_k > 0);
                e_ovf  = (m_disp > 9999);
            end
            @(negedge clk);
            chk("model_S",    int'(bus.S),    int'(e_s));
            chk("model_AN",   int'(bus.AN),   int'(e_an));
            chk("model_busy", int'(bus.busy), int'(e_busy));
            chk("model_done", int'(bus.done), int'(e_done));
            chk("model_ovf",  int'(bus.ovf),  int'(e_ovf));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Record S per slot over one full scan.
    task automatic capture();
        for (int i = 0; i < ND * SD; i++) begin
            @(negedge clk);
            for (int j = 0; j < ND; j++) if (bus.AN[j]) slot_s[j] = bus.S;
        end
    endtask

    task automatic check_slots(input string name, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        capture();
        chk({name, "_slot0"}, int'(slot_s[0]), int'(e0));
        chk({name, "_slot1"}, int'(slot_s[1]), int'(e1));
        chk({name, "_slot2"}, int'(slot_s[2]), int'(e2));
        chk({name, "_slot3"}, int'(slot_s[3]), int'(e3));
    endtask

    // Issue a load, optionally re-pulse load at cycle at2, and measure the
    // number of busy cycles and the cycle done appears (cycle 1 = first
    // cycle after load is sampled).
    task automatic do_load(input int v, input int v2, input int at2,
                           output int busy_n, output int done_at);
        @(negedge clk);
        bus.load = 1'b1; bus.value = DW'(v);
        @(negedge clk);
        bus.load = 1'b0;
        busy_n = 0; done_at = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (n == at2) begin
                bus.load = 1'b1; bus.value = DW'(v2);
            end else begin
                bus.load = 1'b0;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_at = n;
                break;
            end
        end
        bus.load = 1'b0;
        if (done_at < 0) chk("done_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bn, da, dcnt;
        bus.load = 1'b0; bus.value = '0; bus.blank_zeros = 1'b0;
        cyc(3);
        chk("reset_AN", int'(bus.AN), 0);
        chk("reset_S",  int'(bus.S), 0);
        rst_n = 1'b1;

        // First cycle after release, then AN walk every SD cycles.
        @(negedge clk);
        chk("first_AN", int'(bus.AN), 1);
        chk("first_S",  int'(bus.S), 'h7E);
        cyc(SD); chk("walk_AN1", int'(bus.AN), 2);
        cyc(SD); chk("walk_AN2", int'(bus.AN), 4);
        cyc(SD); chk("walk_AN3", int'(bus.AN), 8);
        cyc(SD); chk("walk_AN4", int'(bus.AN), 1);
        check_slots("idle_zero", 7'h7E, 7'h7E, 7'h7E, 7'h7E);

        // 1234: latency and digit patterns.
        do_load(1234, 0, 0, bn, da);
        chk("1234_busy_cycles", bn, 15);
        chk("1234_done_at", da, 16);
        chk("1234_ovf", int'(bus.ovf), 0);
        check_slots("1234", 7'h33, 7'h79, 7'h6D, 7'h30);

        // Overflow boundary.
        do_load(10000, 0, 0, bn, da);
        chk("10000_ovf", int'(bus.ovf), 1);
        check_slots("10000", 7'h01, 7'h01, 7'h01, 7'h01);
        do_load(9999, 0, 0, bn, da);
        chk("9999_ovf", int'(bus.ovf), 0);
        check_slots("9999", 7'h7B, 7'h7B, 7'h7B, 7'h7B);

        // Leading-zero blanking, then live toggle.
        bus.blank_zeros = 1'b1;
        do_load(7, 0, 0, bn, da);
        check_slots("7_blank", 7'h70, 7'h00, 7'h00, 7'h00);
        @(negedge clk); bus.blank_zeros = 1'b0;
        cyc(SD);
        check_slots("7_noblank", 7'h70, 7'h7E, 7'h7E, 7'h7E);

        // Load while busy is ignored.
        do_load(1111, 42, 5, bn, da);
        chk("reload_done_at", da, 16);
        check_slots("1111", 7'h30, 7'h30, 7'h30, 7'h30);

        // Reset during SHIFT aborts the conversion.
        @(negedge clk); bus.load = 1'b1; bus.value = DW'(1234);
        @(negedge clk); bus.load = 1'b0;
        cyc(5);
        chk("mid_busy_before_reset", int'(bus.busy), 1);
        rst_n = 1'b0;
        cyc(2);
        chk("mid_busy_in_reset", int'(bus.busy), 0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("mid_no_done", dcnt, 0);
        chk("mid_busy_after", int'(bus.busy), 0);
        check_slots("after_abort", 7'h7E, 7'h7E, 7'h7E, 7'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
